sram_arbiter: RTL and testbench

Sequencer and arbiter for the single-port 32-bit external SRAM shared by instruction fetch and data access. It sits between the MMU, which supplies translated 20-bit word addresses, a 4-bit memory op and a byte offset, and the SRAM pins. It serialises fetch and load/store requests and generates the SRAM control strobes with a configurable wait-state count. It drives a pipeline stall while any request is outstanding.

---
 rtl/sram_arbiter_if.sv | 35 +++
 rtl/sram_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Bundle of the MMU-side request/response signals and the external SRAM pins.
// The arbiter takes the slave view; the environment (MMU, pads) takes the master view.
interface sram_arbiter_if;
   logic        inst_req;
   logic [19:0] inst_addr;
   logic [3:0]  data_op;
   logic [19:0] data_addr;
   logic [1:0]  data_bytes;
   logic [31:0] data_wdata;
   logic [31:0] inst_rdata;
   logic        inst_done;
   logic [31:0] data_rdata;
   logic        data_done;
   logic        stall;
   logic [19:0] sram_addr;
   logic [31:0] sram_wdata;
   logic        sram_data_oe;
   logic [31:0] sram_rdata;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_we_n;
   logic [3:0]  sram_be_n;

   modport slave (
      input  inst_req, inst_addr, data_op, data_addr, data_bytes, data_wdata, sram_rdata,
      output inst_rdata, inst_done, data_rdata, data_done, stall,
             sram_addr, sram_wdata, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
   );

   modport master (
      output inst_req, inst_addr, data_op, data_addr, data_bytes, data_wdata, sram_rdata,
      input  inst_rdata, inst_done, data_rdata, data_done, stall,
             sram_addr, sram_wdata, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
   );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin fetch/data arbiter and strobe sequencer for a single-port 32-bit SRAM.
// Every SRAM-facing output is registered; only stall is combinational.
module sram_arbiter #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic          clk,
   input  logic          rst,
   sram_arbiter_if.slave bus
);
   localparam logic [3:0] MEM_LB  = 4'd1;
   localparam logic [3:0] MEM_LH  = 4'd2;
   localparam logic [3:0] MEM_LW  = 4'd3;
   localparam logic [3:0] MEM_LBU = 4'd4;
   localparam logic [3:0] MEM_LHU = 4'd5;
   localparam logic [3:0] MEM_SB  = 4'd6;
   localparam logic [3:0] MEM_SH  = 4'd7;
   localparam logic [3:0] MEM_SW  = 4'd8;
   localparam logic [2:0] CNT_LAST = 3'(WAIT_CYCLES);

   typedef enum logic [2:0] {IDLE, INST_RD, DATA_RD, DATA_WR, WR_HOLD} state_t;

   state_t      state_reg, state_next;
   logic [2:0]  cnt_reg, cnt_next;
   logic        last_data_reg, last_data_next;
   logic [19:0] addr_reg, addr_next;
   logic [31:0] wdata_reg, wdata_next;
   logic        ce_n_reg, ce_n_next;
   logic        oe_n_reg, oe_n_next;
   logic        we_n_reg, we_n_next;
   logic [3:0]  be_n_reg, be_n_next;
   logic        data_oe_reg, data_oe_next;
   logic [31:0] inst_rdata_reg, inst_rdata_next;
   logic [31:0] data_rdata_reg, data_rdata_next;
   logic        inst_done_reg, inst_done_next;
   logic        data_done_reg, data_done_next;

   logic        is_load, is_store, data_pending;
   logic [3:0]  sb_be_n;

   assign is_load      = bus.data_op inside {MEM_LW, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU};
   assign is_store     = bus.data_op inside {MEM_SW, MEM_SH, MEM_SB};
   assign data_pending = is_load | is_store;

   // Byte store: every lane disabled except the one selected by the byte offset.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sb_be
         assign sb_be_n[gi] = (bus.data_bytes != 2'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= 3'd0;
         last_data_reg  <= 1'b0;
         addr_reg       <= 20'd0;
         wdata_reg      <= 32'd0;
         ce_n_reg       <= 1'b1;
         oe_n_reg       <= 1'b1;
         we_n_reg       <= 1'b1;
         be_n_reg       <= 4'hF;
         data_oe_reg    <= 1'b0;
         inst_rdata_reg <= 32'd0;
         data_rdata_reg <= 32'd0;
         inst_done_reg  <= 1'b0;
         data_done_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         last_data_reg  <= last_data_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
         ce_n_reg       <= ce_n_next;
         oe_n_reg       <= oe_n_next;
         we_n_reg       <= we_n_next;
         be_n_reg       <= be_n_next;
         data_oe_reg    <= data_oe_next;
         inst_rdata_reg <= inst_rdata_next;
         data_rdata_reg <= data_rdata_next;
         inst_done_reg  <= inst_done_next;
         data_done_reg  <= data_done_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      last_data_next  = last_data_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      ce_n_next       = ce_n_reg;
      oe_n_next       = oe_n_reg;
      we_n_next       = we_n_reg;
      be_n_next       = be_n_reg;
      data_oe_next    = data_oe_reg;
      inst_rdata_next = inst_rdata_reg;
      data_rdata_next = data_rdata_reg;
      inst_done_next  = 1'b0;
      data_done_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            // A done pulse means the pipeline is still advancing; granting now would re-serve it.
            if (!inst_done_reg && !data_done_reg) begin
               if (data_pending && (!bus.inst_req || !last_data_reg)) begin
                  last_data_next = 1'b1;
                  cnt_next       = 3'd0;
                  addr_next      = bus.data_addr;
                  ce_n_next      = 1'b0;
                  if (is_load) begin
                     state_next = DATA_RD;
                     oe_n_next  = 1'b0;
                     be_n_next  = 4'h0;
                  end else begin
                     state_next   = DATA_WR;
                     we_n_next    = 1'b0;
                     data_oe_next = 1'b1;
                     if (bus.data_op == MEM_SH) begin
                        be_n_next  = bus.data_bytes[1] ? 4'b0011 : 4'b1100;
                        wdata_next = {2{bus.data_wdata[15:0]}};
                     end else if (bus.data_op == MEM_SB) begin
                        be_n_next  = sb_be_n;
                        wdata_next = {4{bus.data_wdata[7:0]}};
                     end else begin
                        be_n_next  = 4'h0;
                        wdata_next = bus.data_wdata;
                     end
                  end
               end else if (bus.inst_req) begin
                  last_data_next = 1'b0;
                  cnt_next       = 3'd0;
                  addr_next      = bus.inst_addr;
                  state_next     = INST_RD;
                  ce_n_next      = 1'b0;
                  oe_n_next      = 1'b0;
                  be_n_next      = 4'h0;
               end
            end
         end
         INST_RD, DATA_RD: begin
            if (cnt_reg == CNT_LAST) begin
               state_next = IDLE;
               ce_n_next  = 1'b1;
               oe_n_next  = 1'b1;
               be_n_next  = 4'hF;
               if (state_reg == INST_RD) begin
                  inst_rdata_next = bus.sram_rdata;
                  inst_done_next  = 1'b1;
               end else begin
                  data_rdata_next = bus.sram_rdata;
                  data_done_next  = 1'b1;
               end
            end else begin
               cnt_next = cnt_reg + 3'd1;
            end
         end
         DATA_WR: begin
            if (cnt_reg == CNT_LAST) begin
               state_next = WR_HOLD;
               we_n_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg + 3'd1;
            end
         end
         WR_HOLD: begin
            state_next     = IDLE;
            data_done_next = 1'b1;
            ce_n_next      = 1'b1;
            be_n_next      = 4'hF;
            data_oe_next   = 1'b0;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.sram_addr    = addr_reg;
   assign bus.sram_wdata   = wdata_reg;
   assign bus.sram_ce_n    = ce_n_reg;
   assign bus.sram_oe_n    = oe_n_reg;
   assign bus.sram_we_n    = we_n_reg;
   assign bus.sram_be_n    = be_n_reg;
   assign bus.sram_data_oe = data_oe_reg;
   assign bus.inst_rdata   = inst_rdata_reg;
   assign bus.data_rdata   = data_rdata_reg;
   assign bus.inst_done    = inst_done_reg;
   assign bus.data_done    = data_done_reg;
   assign bus.stall        = (data_pending & ~data_done_reg) | (bus.inst_req & ~inst_done_reg);
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with WAIT_CYCLES=1; cycle 0 is the IDLE cycle a request is first seen.
module tb_sram_arbiter;
   localparam logic [3:0] MEM_NOP = 4'd0;
   localparam logic [3:0] MEM_LW  = 4'd3;
   localparam logic [3:0] MEM_SB  = 4'd6;
   localparam logic [3:0] MEM_SH  = 4'd7;
   localparam logic [3:0] MEM_SW  = 4'd8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   sram_arbiter_if bus();

   sram_arbiter #(.WAIT_CYCLES(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to the next cycle and settle 2 time units past the edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.inst_req   = 1'b1;
      bus.inst_addr  = 20'h00999;
      bus.data_op    = MEM_SW;
      bus.data_addr  = 20'h00888;
      bus.data_bytes = 2'd0;
      bus.data_wdata = 32'h12345678;
      bus.sram_rdata = 32'h0;

      // Reset with both sides requesting.
      step(); step(); step();
      check("rst_ce_n", 32'(bus.sram_ce_n), 32'd1);
      check("rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
      check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
      check("rst_be_n", 32'(bus.sram_be_n), 32'hF);
      check("rst_data_oe", 32'(bus.sram_data_oe), 32'd0);
      check("rst_done", 32'({bus.inst_done, bus.data_done}), 32'd0);
      check("rst_addr", 32'(bus.sram_addr), 32'd0);
      check("rst_stall", 32'(bus.stall), 32'd1);
      $display("reset with fetch+SW pending checked");
      bus.inst_req = 1'b0;
      bus.data_op  = MEM_NOP;
      #1 check("idle_stall", 32'(bus.stall), 32'd0);
      rst = 1'b0;
      step();

      // Fetch at 0x00123.
      bus.inst_req   = 1'b1;
      bus.inst_addr  = 20'h00123;
      bus.sram_rdata = 32'hDEADBEEF;
      #1 check("f_c0_stall", 32'(bus.stall), 32'd1);
      step();
      check("f_c1_oe_n", 32'(bus.sram_oe_n), 32'd0);
      check("f_c1_addr", 32'(bus.sram_addr), 32'h00123);
      check("f_c1_done", 32'(bus.inst_done), 32'd0);
      step();
      check("f_c2_oe_n", 32'(bus.sram_oe_n), 32'd0);
      step();
      check("f_c3_done", 32'(bus.inst_done), 32'd1);
      check("f_c3_rdata", bus.inst_rdata, 32'hDEADBEEF);
      check("f_c3_stall", 32'(bus.stall), 32'd0);
      check("f_c3_oe_n", 32'(bus.sram_oe_n), 32'd1);
      bus.inst_req = 1'b0;
      $display("fetch addr=00123 rdata=%h", bus.inst_rdata);
      step();
      check("f_c4_done", 32'(bus.inst_done), 32'd0);
      check("f_c4_hold", bus.inst_rdata, 32'hDEADBEEF);

      // SB, byte offset 2.
      bus.data_op    = MEM_SB;
      bus.data_addr  = 20'h00456;
      bus.data_bytes = 2'd2;
      bus.data_wdata = 32'h000000A5;
      step();
      check("sb_c1_we_n", 32'(bus.sram_we_n), 32'd0);
      check("sb_c1_be_n", 32'(bus.sram_be_n), 32'b1011);
      check("sb_c1_wdata", bus.sram_wdata, 32'hA5A5A5A5);
      check("sb_c1_data_oe", 32'(bus.sram_data_oe), 32'd1);
      check("sb_c1_addr", 32'(bus.sram_addr), 32'h00456);
      step();
      check("sb_c2_we_n", 32'(bus.sram_we_n), 32'd0);
      step();
      check("sb_c3_we_n", 32'(bus.sram_we_n), 32'd1);
      check("sb_c3_ce_n", 32'(bus.sram_ce_n), 32'd0);
      check("sb_c3_data_oe", 32'(bus.sram_data_oe), 32'd1);
      check("sb_c3_done", 32'(bus.data_done), 32'd0);
      step();
      check("sb_c4_done", 32'(bus.data_done), 32'd1);
      check("sb_c4_data_oe", 32'(bus.sram_data_oe), 32'd0);
      check("sb_c4_stall", 32'(bus.stall), 32'd0);
      bus.data_op = MEM_NOP;
      $display("store SB addr=00456 wdata=%h be_n=1011", bus.sram_wdata);
      step();
      check("sb_c5_done", 32'(bus.data_done), 32'd0);

      // SH, byte offset 2.
      bus.data_op    = MEM_SH;
      bus.data_addr  = 20'h00789;
      bus.data_wdata = 32'h00001234;
      step();
      check("sh_c1_be_n", 32'(bus.sram_be_n), 32'b0011);
      check("sh_c1_wdata", bus.sram_wdata, 32'h12341234);
      step(); step(); step();
      check("sh_c4_done", 32'(bus.data_done), 32'd1);
      bus.data_op = MEM_NOP;
      $display("store SH addr=00789 wdata=%h be_n=0011", bus.sram_wdata);
      step();

      // Round-robin from a fresh reset: LW wins the first tie.
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      bus.inst_req   = 1'b1;
      bus.inst_addr  = 20'h00AAA;
      bus.data_op    = MEM_LW;
      bus.data_addr  = 20'h00BBB;
      bus.sram_rdata = 32'h11112222;
      step();
      check("rr1_addr", 32'(bus.sram_addr), 32'h00BBB);
      check("rr1_oe_n", 32'(bus.sram_oe_n), 32'd0);
      step(); step();
      check("rr1_ddone", 32'(bus.data_done), 32'd1);
      check("rr1_drdata", bus.data_rdata, 32'h11112222);
      check("rr1_idone", 32'(bus.inst_done), 32'd0);
      check("rr1_stall", 32'(bus.stall), 32'd1);
      $display("load LW addr=00BBB rdata=%h", bus.data_rdata);
      bus.data_addr  = 20'h00CCC;
      bus.sram_rdata = 32'h33334444;
      step();
      check("rr1_nogrant", 32'(bus.sram_ce_n), 32'd1);
      step();
      check("rr2_addr", 32'(bus.sram_addr), 32'h00AAA);
      step(); step();
      check("rr2_idone", 32'(bus.inst_done), 32'd1);
      check("rr2_irdata", bus.inst_rdata, 32'h33334444);
      check("rr2_ddone", 32'(bus.data_done), 32'd0);
      $display("fetch addr=00AAA rdata=%h", bus.inst_rdata);
      bus.inst_req   = 1'b0;
      bus.sram_rdata = 32'h55556666;
      step();
      check("rr2_nogrant", 32'(bus.sram_ce_n), 32'd1);
      step();
      check("rr3_addr", 32'(bus.sram_addr), 32'h00CCC);
      step(); step();
      check("rr3_ddone", 32'(bus.data_done), 32'd1);
      check("rr3_drdata", bus.data_rdata, 32'h55556666);
      $display("load LW addr=00CCC rdata=%h", bus.data_rdata);
      bus.data_op = MEM_NOP;
      step();

      // Reset during the second DATA_WR cycle of an SW, then restart.
      bus.data_op    = MEM_SW;
      bus.data_addr  = 20'h00321;
      bus.data_wdata = 32'hCAFEF00D;
      step();
      step();
      check("rw_c2_we_n", 32'(bus.sram_we_n), 32'd0);
      rst = 1'b1;
      step();
      check("rw_rst_we_n", 32'(bus.sram_we_n), 32'd1);
      check("rw_rst_data_oe", 32'(bus.sram_data_oe), 32'd0);
      check("rw_rst_ce_n", 32'(bus.sram_ce_n), 32'd1);
      check("rw_rst_done", 32'(bus.data_done), 32'd0);
      rst = 1'b0;
      step();
      check("rw_re_we_n", 32'(bus.sram_we_n), 32'd0);
      check("rw_re_wdata", bus.sram_wdata, 32'hCAFEF00D);
      check("rw_re_be_n", 32'(bus.sram_be_n), 32'h0);
      step(); step();
      check("rw_hold_done", 32'(bus.data_done), 32'd0);
      step();
      check("rw_done", 32'(bus.data_done), 32'd1);
      $display("store SW addr=00321 wdata=%h after reset restart", bus.sram_wdata);
      bus.data_op = MEM_NOP;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
